// File: rtl/cpu_pkg.sv
// Shared vector CPU definitions: fetch FSM states, Id opcodes and instruction field positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_PSE = 4'd1;
  localparam logic [3:0] OP_SEL = 4'd2;
  localparam logic [3:0] OP_END = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd12;
  localparam logic [3:0] OP_JEQ = 4'd13;
  localparam logic [3:0] OP_JLT = 4'd14;

  localparam int ID_MSB  = 31;
  localparam int ID_LSB  = 28;
  localparam int IMM_MSB = 27;
  localparam int IMM_LSB = 26;

  // Opcodes that may make pc_control_unit raise redirect when taken.
  function automatic logic is_redirect_op(input logic [3:0] id);
    return (id == OP_PSE) || (id == OP_SEL) || (id == OP_JMP) ||
           (id == OP_JEQ) || (id == OP_JLT);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding a ROM response that arrived while the fetch stage was stalled.
module fetch_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_kill,
  input  logic         i_markKill,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic         o_kill,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic         r_kill;
  logic [W-1:0] r_data;

  // A killed entry is still held so it occupies its slot, but is dropped when popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_kill  <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_kill  <= i_kill;
      r_data  <= i_data;
    end else if (i_pop) begin
      r_valid <= 1'b0;
      r_kill  <= 1'b0;
    end else if (i_markKill && r_valid) begin
      r_kill  <= 1'b1;
    end
  end

  assign o_valid = r_valid;
  assign o_kill  = r_kill;
  assign o_data  = r_data;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues ROM reads at pc, registers the returned word and handles stall/redirect/END.
// Optional macro FETCH_PERF_EN adds fetch_count/bubble_count performance counters.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int             I        = 32,
  parameter int             ADDR_W   = 28,
  parameter logic [I-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [I-1:0]      pc,
  input  logic              redirect,
  input  logic              stall,
  output logic [I-1:0]      imem_addr,
  output logic              imem_rd,
  input  logic [I-1:0]      imem_rdata,
  output logic [I-1:0]      instr,
  output logic              instr_valid,
  output logic [3:0]        Id,
  output logic [ADDR_W-1:0] Address,
  output logic [1:0]        Imm,
`ifdef FETCH_PERF_EN
  output logic [31:0]       fetch_count,
  output logic [31:0]       bubble_count,
`endif
  output logic              halted
);

  fetch_state_t r_state;
  fetch_state_t w_nextState;

  logic         r_inflight;
  logic [I-1:0] r_instr;
  logic         r_instrValid;
  logic         r_halted;

  logic         w_imemRd;
  logic [I-1:0] w_imemAddr;
  logic         w_load;
  logic [I-1:0] w_loadData;
  logic         w_clearValid;

  logic         w_skidLoad;
  logic         w_skidKillIn;
  logic         w_skidMarkKill;
  logic         w_skidPop;
  logic         w_skidValid;
  logic         w_skidKill;
  logic [I-1:0] w_skidData;

  fetch_skid_buf #(.W(I)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_skidLoad),
    .i_kill     (w_skidKillIn),
    .i_markKill (w_skidMarkKill),
    .i_pop      (w_skidPop),
    .i_data     (imem_rdata),
    .o_valid    (w_skidValid),
    .o_kill     (w_skidKill),
    .o_data     (w_skidData)
  );

  // The response on imem_rdata belongs to the read issued last cycle (r_inflight);
  // a redirect this cycle makes that response stale, so it is dropped rather than loaded.
  always_comb begin
    w_nextState    = r_state;
    w_imemRd       = 1'b0;
    w_imemAddr     = pc;
    w_load         = 1'b0;
    w_loadData     = imem_rdata;
    w_clearValid   = 1'b0;
    w_skidLoad     = 1'b0;
    w_skidKillIn   = 1'b0;
    w_skidMarkKill = 1'b0;
    w_skidPop      = 1'b0;

    case (r_state)
      IDLE: begin
        w_imemAddr = RESET_PC;
        if (start) begin
          w_imemRd    = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (stall) begin
          w_skidLoad   = r_inflight;
          w_skidKillIn = redirect;
          w_nextState  = HOLD;
        end else begin
          w_imemRd = 1'b1;
          if (r_inflight && !redirect) begin
            w_load = 1'b1;
          end else begin
            w_clearValid = 1'b1;
          end
        end
      end
      HOLD: begin
        if (stall) begin
          w_skidMarkKill = redirect;
        end else begin
          w_imemRd    = 1'b1;
          w_skidPop   = w_skidValid;
          w_loadData  = w_skidData;
          w_nextState = RUN;
          if (w_skidValid && !w_skidKill && !redirect) begin
            w_load = 1'b1;
          end else begin
            w_clearValid = 1'b1;
          end
        end
      end
      HALT: begin
        w_imemAddr = pc;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    if (w_load && (w_loadData[ID_MSB:ID_LSB] == OP_END)) begin
      w_nextState = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_inflight   <= 1'b0;
      r_instr      <= {OP_NOP, {(I-4){1'b0}}};
      r_instrValid <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_inflight <= w_imemRd;
      r_halted   <= (w_nextState == HALT);
      if (w_load) begin
        r_instr      <= w_loadData;
        r_instrValid <= 1'b1;
      end else if (w_clearValid) begin
        r_instrValid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetchCount;
  logic [31:0] r_bubbleCount;

  // Both counters stick at all-ones; nothing loads or runs in HALT, so they freeze there.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetchCount  <= '0;
      r_bubbleCount <= '0;
    end else begin
      if (w_load && (r_fetchCount != '1)) begin
        r_fetchCount <= r_fetchCount + 32'd1;
      end
      if ((r_state == RUN) && !r_instrValid && (r_bubbleCount != '1)) begin
        r_bubbleCount <= r_bubbleCount + 32'd1;
      end
    end
  end

  assign fetch_count  = r_fetchCount;
  assign bubble_count = r_bubbleCount;
`endif

  assign imem_rd     = w_imemRd;
  assign imem_addr   = w_imemAddr;
  assign instr       = r_instr;
  assign instr_valid = r_instrValid;
  assign halted      = r_halted;
  assign Id          = r_instr[ID_MSB:ID_LSB];
  assign Address     = r_instr[ADDR_W-1:0];
  assign Imm         = r_instr[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a behavioural synchronous ROM.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] pc;
  logic        redirect;
  logic        stall;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [3:0]  Id;
  logic [27:0] Address;
  logic [1:0]  Imm;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int nChecks;
  int nFail;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pc          (pc),
    .redirect    (redirect),
    .stall       (stall),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .Id          (Id),
    .Address     (Address),
    .Imm         (Imm),
`ifdef FETCH_PERF_EN
    .fetch_count (fetch_count),
    .bubble_count(bubble_count),
`endif
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM image: NOPs at 0/4, JMP 0x40 at 8, straight-line code at 0x40.., END at 0x50.
  function automatic logic [31:0] romWord(input logic [31:0] a);
    case (a)
      32'h00:  return 32'h0000_0001;
      32'h04:  return 32'h0000_0002;
      32'h08:  return 32'hC000_0040;
      32'h0C:  return 32'h0000_0003;
      32'h40:  return 32'h0C00_0044;
      32'h44:  return 32'h0000_0045;
      32'h48:  return 32'h0000_0046;
      32'h4C:  return 32'h0000_0047;
      32'h50:  return 32'h3000_0000;
      default: return 32'h5A5A_0000 | {16'h0000, a[15:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (imem_rd) imem_rdata <= romWord(imem_addr);
  end

  task automatic applyStimulus(input logic s, input logic [31:0] p,
                               input logic rdr, input logic stl);
    @(negedge clk);
    start    = s;
    pc       = p;
    redirect = rdr;
    stall    = stl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    nChecks    = 0;
    nFail      = 0;
    reset      = 1'b1;
    start      = 1'b0;
    pc         = 32'h0;
    redirect   = 1'b0;
    stall      = 1'b0;
    imem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_valid", 32'(instr_valid), 32'h0);
    checkOutput("rst_rd",    32'(imem_rd),     32'h0);
    checkOutput("rst_addr",  imem_addr,        32'h0);
    checkOutput("rst_instr", instr,            32'h0);
    checkOutput("rst_halt",  32'(halted),      32'h0);
    reset = 1'b0;

    // Start and straight-line fetch
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    checkOutput("c0_rd",   32'(imem_rd), 32'h1);
    checkOutput("c0_addr", imem_addr,    32'h0);
    applyStimulus(1'b0, 32'h4, 1'b0, 1'b0);
    checkOutput("c1_addr",  imem_addr,        32'h4);
    checkOutput("c1_valid", 32'(instr_valid), 32'h0);
    applyStimulus(1'b0, 32'h8, 1'b0, 1'b0);
    checkOutput("c2_valid", 32'(instr_valid), 32'h1);
    checkOutput("c2_instr", instr,            32'h0000_0001);
    checkOutput("c2_id",    32'(Id),          32'h0);
    checkOutput("c2_addr",  imem_addr,        32'h8);
    applyStimulus(1'b0, 32'hC, 1'b0, 1'b0);
    checkOutput("c3_instr", instr,     32'h0000_0002);
    checkOutput("c3_addr",  imem_addr, 32'hC);

    // JMP 0x40 presented; redirect drops the word from 0xC
    applyStimulus(1'b0, 32'h40, 1'b1, 1'b0);
    checkOutput("c4_id",   32'(Id),      32'hC);
    checkOutput("c4_fld",  32'(Address), 32'h40);
    checkOutput("c4_addr", imem_addr,    32'h40);
    checkOutput("c4_rd",   32'(imem_rd), 32'h1);
    applyStimulus(1'b0, 32'h44, 1'b0, 1'b0);
    checkOutput("c5_bubble", 32'(instr_valid), 32'h0);
    applyStimulus(1'b0, 32'h48, 1'b0, 1'b0);
    checkOutput("c6_instr", instr,            32'h0C00_0044);
    checkOutput("c6_valid", 32'(instr_valid), 32'h1);
    checkOutput("c6_imm",   32'(Imm),         32'h3);
    checkOutput("c6_fld",   32'(Address),     32'h0C00_0044);

    // Three-cycle stall with the 0x48 word in flight
    applyStimulus(1'b0, 32'h4C, 1'b0, 1'b1);
    checkOutput("c7_rd",    32'(imem_rd), 32'h0);
    checkOutput("c7_instr", instr,        32'h0000_0045);
    applyStimulus(1'b0, 32'h4C, 1'b0, 1'b1);
    checkOutput("c8_instr", instr,            32'h0000_0045);
    checkOutput("c8_valid", 32'(instr_valid), 32'h1);
    checkOutput("c8_rd",    32'(imem_rd),     32'h0);
    applyStimulus(1'b0, 32'h4C, 1'b0, 1'b1);
    checkOutput("c9_instr", instr,        32'h0000_0045);
    checkOutput("c9_rd",    32'(imem_rd), 32'h0);
    applyStimulus(1'b0, 32'h4C, 1'b0, 1'b0);
    checkOutput("c10_rd",    32'(imem_rd), 32'h1);
    checkOutput("c10_addr",  imem_addr,    32'h4C);
    checkOutput("c10_instr", instr,        32'h0000_0045);
    applyStimulus(1'b0, 32'h50, 1'b0, 1'b0);
    checkOutput("c11_skid", instr, 32'h0000_0046);
    applyStimulus(1'b0, 32'h54, 1'b0, 1'b0);
    checkOutput("c12_instr", instr,       32'h0000_0047);
    checkOutput("c12_halt",  32'(halted), 32'h0);

    // END delivered, start pulses ignored
    applyStimulus(1'b1, 32'h58, 1'b0, 1'b0);
    checkOutput("c13_halt",  32'(halted),  32'h1);
    checkOutput("c13_id",    32'(Id),      32'h3);
    checkOutput("c13_rd",    32'(imem_rd), 32'h0);
    applyStimulus(1'b1, 32'h58, 1'b0, 1'b0);
    checkOutput("c14_halt",  32'(halted),  32'h1);
    checkOutput("c14_rd",    32'(imem_rd), 32'h0);
    checkOutput("c14_instr", instr,        32'h3000_0000);
    applyStimulus(1'b0, 32'h58, 1'b0, 1'b0);
    checkOutput("c15_rd", 32'(imem_rd), 32'h0);

    // Reset out of HALT
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("r_halt",  32'(halted),      32'h0);
    checkOutput("r_valid", 32'(instr_valid), 32'h0);
    checkOutput("r_instr", instr,            32'h0);

    // Reset while stalled with a full skid entry
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    checkOutput("d0_rd", 32'(imem_rd), 32'h1);
    applyStimulus(1'b0, 32'h4, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h8, 1'b0, 1'b0);
    checkOutput("d2_instr", instr, 32'h0000_0001);
    applyStimulus(1'b0, 32'hC, 1'b0, 1'b1);
    checkOutput("d3_instr", instr, 32'h0000_0002);
    applyStimulus(1'b0, 32'hC, 1'b0, 1'b1);
    reset = 1'b1;
    checkOutput("d4_rd", 32'(imem_rd), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("d5_valid", 32'(instr_valid), 32'h0);
    checkOutput("d5_instr", instr,            32'h0);
    checkOutput("d5_rd",    32'(imem_rd),     32'h0);

    // Redirect together with stall: captured word is killed on release
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h4, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h8, 1'b0, 1'b0);
    checkOutput("e2_instr", instr, 32'h0000_0001);
    applyStimulus(1'b0, 32'h40, 1'b1, 1'b1);
    checkOutput("e3_rd",    32'(imem_rd), 32'h0);
    checkOutput("e3_instr", instr,        32'h0000_0002);
    applyStimulus(1'b0, 32'h40, 1'b0, 1'b0);
    checkOutput("e4_addr",  imem_addr, 32'h40);
    checkOutput("e4_instr", instr,     32'h0000_0002);
    applyStimulus(1'b0, 32'h44, 1'b0, 1'b0);
    checkOutput("e5_valid", 32'(instr_valid), 32'h0);
    applyStimulus(1'b0, 32'h48, 1'b0, 1'b0);
    checkOutput("e6_instr", instr,            32'h0C00_0044);
    checkOutput("e6_valid", 32'(instr_valid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
